// File: rtl/texture_stream_uploader.sv
`default_nettype none
// ============================================================================
// Module   : texture_stream_uploader
// Purpose  : Reads a 2^w x 2^h texture out of a texel memory in linear order
//            and emits it as an AXI4-Stream of packed pixels (PPB texels per
//            beat, texel k of a beat at tdata[k*PIXEL_WIDTH +: PIXEL_WIDTH]).
// Options  : TEXTURE_UPLOADER_BYTE_SWAP_EN - reverse the bytes of every texel
//            before packing (PIXEL_WIDTH must be a multiple of 8).
// Revision : 1.0 - initial release
// ============================================================================
module texture_stream_uploader #(
    parameter int STREAM_WIDTH   = 32,
    parameter int PIXEL_WIDTH    = 16,
    parameter int TEX_ADDR_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [3:0]                texSizeLog2Width,
    input  logic [3:0]                texSizeLog2Height,
    output logic                      busy,
    output logic                      done,
    output logic                      sizeError,
    output logic                      texelReadEn,
    output logic [TEX_ADDR_WIDTH-1:0] texelReadAddr,
    input  logic [PIXEL_WIDTH-1:0]    texelReadData,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [STREAM_WIDTH-1:0]   m_axis_tdata
);

    localparam int PPB    = STREAM_WIDTH / PIXEL_WIDTH;
    localparam int SLOT_W = (PPB > 1) ? $clog2(PPB) : 1;
    // One extra bit so a full 2^TEX_ADDR_WIDTH texture count does not wrap.
    localparam int CNT_W  = TEX_ADDR_WIDTH + 1;

    localparam logic [SLOT_W-1:0] c_LAST_SLOT = SLOT_W'(PPB - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]              state_q,    state_d;
    logic [CNT_W-1:0]        n_q,        n_d;        // texels in this upload
    logic [CNT_W-1:0]        rd_cnt_q,   rd_cnt_d;   // reads issued
    logic [CNT_W-1:0]        pl_cnt_q,   pl_cnt_d;   // texels placed into a beat
    logic [SLOT_W-1:0]       slot_q,     slot_d;     // next pack slot
    logic [STREAM_WIDTH-1:0] pack_q,     pack_d;     // partially built beat
    logic                    flush_q,    flush_d;    // partial last beat waiting
    logic                    hold_v_q,   hold_v_d;   // stalled return parked
    logic [PIXEL_WIDTH-1:0]  hold_q,     hold_d;
    logic                    ret_v_q,    ret_v_d;    // read data arrives this cycle
    logic                    tvalid_q,   tvalid_d;
    logic [STREAM_WIDTH-1:0] tdata_q,    tdata_d;
    logic                    tlast_q,    tlast_d;
    logic                    done_q,     done_d;
    logic                    size_err_q, size_err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [4:0]              w_size_sum;
    logic                    w_size_bad;
    logic                    w_start_ok;
    logic                    w_out_free;
    logic                    w_last_hs;
    logic                    w_rd_last;
    logic                    w_src_valid;
    logic [PIXEL_WIDTH-1:0]  w_src_raw;
    logic [PIXEL_WIDTH-1:0]  w_src_px;
    logic                    w_src_last;
    logic                    w_slot_full;
    logic                    w_place;
    logic [STREAM_WIDTH-1:0] w_merged;

    function automatic logic [PIXEL_WIDTH-1:0] f_texel(input logic [PIXEL_WIDTH-1:0] v);
        logic [PIXEL_WIDTH-1:0] r;
`ifdef TEXTURE_UPLOADER_BYTE_SWAP_EN
        for (int b = 0; b < PIXEL_WIDTH / 8; b++) begin
            r[b*8 +: 8] = v[PIXEL_WIDTH-8-b*8 +: 8];
        end
`else
        r = v;
`endif
        return r;
    endfunction

    assign w_size_sum  = {1'b0, texSizeLog2Width} + {1'b0, texSizeLog2Height};
    assign w_size_bad  = (int'(w_size_sum) > TEX_ADDR_WIDTH);
    assign w_start_ok  = (state_q == c_ST_IDLE) && start && !w_size_bad;
    // The output register can take a new beat if empty or draining now.
    assign w_out_free  = !tvalid_q || m_axis_tready;
    assign w_last_hs   = tvalid_q && m_axis_tready && tlast_q;
    assign w_rd_last   = (rd_cnt_q == n_q - CNT_W'(1));

    // The parked texel is always older than anything in flight, so it wins.
    // A return and a parked texel never coexist: reads are only issued while
    // the output can take a beat, and parking only happens when it cannot.
    assign w_src_valid = hold_v_q || ret_v_q;
    assign w_src_raw   = hold_v_q ? hold_q : texelReadData;
    assign w_src_px    = f_texel(w_src_raw);
    assign w_src_last  = (pl_cnt_q == n_q - CNT_W'(1));
    assign w_slot_full = (slot_q == c_LAST_SLOT);
    assign w_place     = w_src_valid && (!w_slot_full || w_out_free);

    // Pack the incoming texel into its slot on top of the beat in progress.
    always_comb begin
        w_merged = pack_q;
        for (int k = 0; k < PPB; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                w_merged[k*PIXEL_WIDTH +: PIXEL_WIDTH] = w_src_px;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: RUN until the last read issues, FLUSH until the last beat is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (w_start_ok) state_d = c_ST_RUN;
            c_ST_RUN:   if (texelReadEn && w_rd_last) state_d = c_ST_FLUSH;
            c_ST_FLUSH: if (w_last_hs) state_d = c_ST_IDLE;
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // FSM outputs: reads issue one per cycle while the output path has room.
    always_comb begin
        busy          = (state_q != c_ST_IDLE);
        texelReadEn   = (state_q == c_ST_RUN) && w_out_free;
        texelReadAddr = rd_cnt_q[TEX_ADDR_WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Next values for counters, pack/hold registers and the output stage.
    always_comb begin
        n_d        = n_q;
        rd_cnt_d   = rd_cnt_q;
        pl_cnt_d   = pl_cnt_q;
        slot_d     = slot_q;
        pack_d     = pack_q;
        flush_d    = flush_q;
        hold_v_d   = 1'b0;
        hold_d     = hold_q;
        ret_v_d    = texelReadEn;
        tvalid_d   = tvalid_q && !m_axis_tready;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        done_d     = w_last_hs;
        size_err_d = (state_q == c_ST_IDLE) && start && w_size_bad;

        if (texelReadEn) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end

        if (w_src_valid && !w_place) begin
            hold_v_d = 1'b1;
            hold_d   = w_src_raw;
        end

        if (w_place) begin
            pl_cnt_d = pl_cnt_q + CNT_W'(1);
            if (w_slot_full) begin
                // Full beat goes straight to the output stage.
                slot_d   = '0;
                pack_d   = '0;
                tvalid_d = 1'b1;
                tdata_d  = w_merged;
                tlast_d  = w_src_last;
            end else begin
                slot_d = slot_q + SLOT_W'(1);
                pack_d = w_merged;
                // A short final beat is pushed out on the following cycle.
                if (w_src_last) begin
                    flush_d = 1'b1;
                end
            end
        end

        if (flush_q && w_out_free) begin
            flush_d  = 1'b0;
            pack_d   = '0;
            slot_d   = '0;
            tvalid_d = 1'b1;
            tdata_d  = pack_q;
            tlast_d  = 1'b1;
        end

        if (w_last_hs) begin
            rd_cnt_d = '0;
        end

        if (w_start_ok) begin
            n_d      = CNT_W'(1) << w_size_sum;
            rd_cnt_d = '0;
            pl_cnt_d = '0;
            slot_d   = '0;
            pack_d   = '0;
            flush_d  = 1'b0;
        end
    end

    // Datapath registers; reset discards any partial beat and in-flight data.
    always_ff @(posedge aclk) begin
        if (reset) begin
            n_q        <= '0;
            rd_cnt_q   <= '0;
            pl_cnt_q   <= '0;
            slot_q     <= '0;
            pack_q     <= '0;
            flush_q    <= 1'b0;
            hold_v_q   <= 1'b0;
            hold_q     <= '0;
            ret_v_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            done_q     <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            n_q        <= n_d;
            rd_cnt_q   <= rd_cnt_d;
            pl_cnt_q   <= pl_cnt_d;
            slot_q     <= slot_d;
            pack_q     <= pack_d;
            flush_q    <= flush_d;
            hold_v_q   <= hold_v_d;
            hold_q     <= hold_d;
            ret_v_q    <= ret_v_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            done_q     <= done_d;
            size_err_q <= size_err_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign done          = done_q;
    assign sizeError     = size_err_q;

endmodule
`default_nettype wire

// File: tb/tb_texture_stream_uploader.sv
`default_nettype none
// ============================================================================
// Module   : tb_texture_stream_uploader
// Purpose  : Self-checking bench for texture_stream_uploader. Expected beats
//            are built from the memory image by plain index arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_texture_stream_uploader;

    localparam int SW  = 32;
    localparam int PW  = 16;
    localparam int AW  = 16;
    localparam int PPB = SW / PW;

    logic          aclk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    texSizeLog2Width;
    logic [3:0]    texSizeLog2Height;
    logic          busy;
    logic          done;
    logic          sizeError;
    logic          texelReadEn;
    logic [AW-1:0] texelReadAddr;
    logic [PW-1:0] texelReadData;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [SW-1:0] m_axis_tdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [PW-1:0] mem [0:1023];

    texture_stream_uploader #(
        .STREAM_WIDTH  (SW),
        .PIXEL_WIDTH   (PW),
        .TEX_ADDR_WIDTH(AW)
    ) dut (
        .aclk             (aclk),
        .reset            (reset),
        .start            (start),
        .texSizeLog2Width (texSizeLog2Width),
        .texSizeLog2Height(texSizeLog2Height),
        .busy             (busy),
        .done             (done),
        .sizeError        (sizeError),
        .texelReadEn      (texelReadEn),
        .texelReadAddr    (texelReadAddr),
        .texelReadData    (texelReadData),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tdata     (m_axis_tdata)
    );

    always #5 aclk = ~aclk;

    // Synchronous memory: data valid the cycle after the read strobe.
    always @(posedge aclk) begin
        if (texelReadEn) texelReadData <= mem[texelReadAddr[9:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] px(input logic [PW-1:0] v);
`ifdef TEXTURE_UPLOADER_BYTE_SWAP_EN
        return {v[7:0], v[15:8]};
`else
        return v;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   64'(busy), 64'(0));
        chk({tag, "_done"},   64'(done), 64'(0));
        chk({tag, "_szerr"},  64'(sizeError), 64'(0));
        chk({tag, "_rden"},   64'(texelReadEn), 64'(0));
        chk({tag, "_rdaddr"}, 64'(texelReadAddr), 64'(0));
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
        chk({tag, "_tlast"},  64'(m_axis_tlast), 64'(0));
        chk({tag, "_tdata"},  64'(m_axis_tdata), 64'(0));
    endtask

    // fill: 0 random, 1 sequential (idx+1), 2 keep current memory contents.
    task automatic run_upload(input int w, input int h, input int fill, input bit rnd_rdy,
                              input int abort_beat, input int poke_cyc,
                              output logic [SW-1:0] beat0);
        int n, nbeats, rd_n, beat_n, sz_n, first_rd, last_rd, first_v, last_hs, done_cyc;
        bit stalled, fin, aborted;
        logic [SW-1:0] prev_data, word;
        logic prev_last;
        logic [SW:0] exp_q[$];
        logic [SW:0] e;

        n = 1 << (w + h);
        nbeats = (n + PPB - 1) / PPB;
        for (int i = 0; i < n; i++) begin
            if (fill == 0) mem[i] = PW'($urandom);
            else if (fill == 1) mem[i] = PW'(i + 1);
        end
        for (int j = 0; j < nbeats; j++) begin
            word = '0;
            for (int k = 0; k < PPB; k++) begin
                if (j * PPB + k < n) word[k*PW +: PW] = px(mem[j*PPB + k]);
            end
            exp_q.push_back({(j == nbeats - 1), word});
        end

        beat0 = '0; rd_n = 0; beat_n = 0; sz_n = 0;
        first_rd = -1; last_rd = -1; first_v = -1; last_hs = -1; done_cyc = -1;
        stalled = 1'b0; fin = 1'b0; aborted = 1'b0;
        prev_data = '0; prev_last = 1'b0;

        // cycle 0: start request
        @(posedge aclk); #1;
        start = 1'b1;
        texSizeLog2Width  = 4'(w);
        texSizeLog2Height = 4'(h);
        m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

        for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
            @(posedge aclk); #1;
            start = 1'b0;
            if (cyc == poke_cyc) begin
                start = 1'b1;
                texSizeLog2Width  = 4'd9;
                texSizeLog2Height = 4'd8;
            end
            m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (sizeError) sz_n++;
            if (stalled) begin
                chk("stall_tvalid", 64'(m_axis_tvalid), 64'(1));
                chk("stall_tdata", 64'(m_axis_tdata), 64'(prev_data));
                chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (texelReadEn) begin
                chk("rd_addr", 64'(texelReadAddr), 64'(rd_n));
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                rd_n++;
            end
            if (m_axis_tvalid && first_v < 0) first_v = cyc;
            if (done) begin
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy), 64'(0));
                fin = 1'b1;
            end else begin
                chk("busy_run", 64'(busy), 64'(1));
            end
            if (abort_beat >= 0 && m_axis_tvalid && beat_n == abort_beat) begin
                aborted = 1'b1;
                fin = 1'b1;
                reset = 1'b1;
            end
            if (!aborted && m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(beat_n + 1), 64'(nbeats));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_axis_tdata), 64'(e[SW-1:0]));
                    chk("beat_last", 64'(m_axis_tlast), 64'(e[SW]));
                end
                if (beat_n == 0) beat0 = m_axis_tdata;
                last_hs = cyc;
                beat_n++;
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
        end

        if (aborted) begin
            @(posedge aclk); #1;
            reset = 1'b0;
            #1;
            chk_all_zero("abort");
            for (int c = 0; c < 4; c++) begin
                @(posedge aclk); #2;
                chk("abort_no_done", 64'(done), 64'(0));
                chk("abort_idle", 64'(busy), 64'(0));
            end
        end else begin
            chk("finished", 64'(fin), 64'(1));
            chk("beat_count", 64'(beat_n), 64'(nbeats));
            chk("read_count", 64'(rd_n), 64'(n));
            chk("no_size_err", 64'(sz_n), 64'(0));
            @(posedge aclk); #2;
            chk("done_single", 64'(done), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_tvalid", 64'(m_axis_tvalid), 64'(0));
            if (!rnd_rdy) begin
                chk("first_read_cyc", 64'(first_rd), 64'(1));
                chk("last_read_cyc", 64'(last_rd), 64'(n));
                chk("first_tvalid_cyc", 64'(first_v), 64'(PPB + 2));
                chk("done_cyc", 64'(done_cyc), 64'(last_hs + 1));
            end
        end
    endtask

    logic [SW-1:0] b0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        texSizeLog2Width  = 4'd0;
        texSizeLog2Height = 4'd0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        chk_all_zero("reset");
        @(posedge aclk); #1;
        reset = 1'b0;

        // 2x2 sequential memory
        run_upload(1, 1, 1, 1'b0, -1, -1, b0);
`ifdef TEXTURE_UPLOADER_BYTE_SWAP_EN
        chk("2x2_beat0", 64'(b0), 64'(32'h0200_0100));
`else
        chk("2x2_beat0", 64'(b0), 64'(32'h0002_0001));
`endif

        // 1x1 single texel, upper slot must be zero
        mem[0] = 16'hABCD;
        run_upload(0, 0, 2, 1'b0, -1, -1, b0);
`ifdef TEXTURE_UPLOADER_BYTE_SWAP_EN
        chk("1x1_beat", 64'(b0), 64'(32'h0000_CDAB));
`else
        chk("1x1_beat", 64'(b0), 64'(32'h0000_ABCD));
`endif

        // 8x8 with random backpressure and an ignored start mid-upload
        run_upload(3, 3, 0, 1'b1, -1, 5, b0);

        // oversize request rejected in IDLE
        @(posedge aclk); #1;
        start = 1'b1;
        texSizeLog2Width  = 4'd9;
        texSizeLog2Height = 4'd8;
        @(posedge aclk); #1;
        start = 1'b0;
        #1;
        chk("size_err_pulse", 64'(sizeError), 64'(1));
        chk("size_err_busy", 64'(busy), 64'(0));
        chk("size_err_rden", 64'(texelReadEn), 64'(0));
        @(posedge aclk); #2;
        chk("size_err_clear", 64'(sizeError), 64'(0));
        chk("size_err_busy2", 64'(busy), 64'(0));

        // 4x4 aborted by reset on its third beat, then a full clean run
        run_upload(2, 2, 0, 1'b0, 2, -1, b0);
        run_upload(2, 2, 0, 1'b0, -1, -1, b0);

        // byte-order pattern
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        run_upload(1, 0, 2, 1'b0, -1, -1, b0);
`ifdef TEXTURE_UPLOADER_BYTE_SWAP_EN
        chk("swap_beat", 64'(b0), 64'(32'h7856_3412));
`else
        chk("swap_beat", 64'(b0), 64'(32'h5678_1234));
`endif

        // random sizes under random backpressure
        for (int t = 0; t < 4; t++) begin
            run_upload(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, 1'b1, -1, -1, b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/texture_stream_uploader.md
# texture_stream_uploader

Streams a power-of-two texture out of a texel memory as an AXI4-Stream of packed pixels, producing exactly the beat format that the texture buffer's write slave consumes. Sits between the texture staging RAM (or a DMA-side memory) and the texture buffer's `s_axis_*` port. It also drives the texture buffer in benches so that upload paths can be looped back without a CPU model.

## Interface
- `STREAM_WIDTH`, 32: AXIS data width; multiple of `PIXEL_WIDTH`.
- `PIXEL_WIDTH`, 16: bits per texel.
- `TEX_ADDR_WIDTH`, 16: texel memory address width.
- Derived `PPB = STREAM_WIDTH / PIXEL_WIDTH` (pixels per beat).

Ports:
- `aclk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin an upload; sampled only in IDLE.
- `texSizeLog2Width`  in  4  log2 of texture width (0 = 1 px).
- `texSizeLog2Height`  in  4  log2 of texture height.
- `busy`  out  1  high from accepted start until last beat accepted.
- `done`  out  1  one-cycle pulse after last beat handshake.
- `sizeError`  out  1  one-cycle pulse when start is rejected for size.
- `texelReadEn`  out  1  memory read strobe.
- `texelReadAddr`  out  `TEX_ADDR_WIDTH`  linear texel address `{t, s}`.
- `texelReadData`  in  `PIXEL_WIDTH`  read data, valid exactly one cycle after `texelReadEn`.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  marks final beat of the texture.
- `m_axis_tdata`  out  `STREAM_WIDTH`  packed pixels, pixel k at bits `[k*PIXEL_WIDTH +: PIXEL_WIDTH]`.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE:
  - On `start`, latch `N = 2^(w+h)` texels. Go to RUN, raise `busy`, reset the read address to 0.
  - If `w+h > TEX_ADDR_WIDTH`, do not start; pulse `sizeError`, stay IDLE.
- RUN:
  - Issue reads at addresses 0..N-1 in order, one per cycle, while the output path has room.
  - Each return is placed into the pack register at slot `count mod PPB`.
  - When a slot PPB-1 fills, or the last texel returns, transfer the packed word to the output stage. Unfilled slots are zero.
  - `tlast` is set on the beat holding texel N-1.
  - After the last read issues, go to FLUSH.
- FLUSH: wait for the last beat's handshake. Then pulse `done`, drop `busy`, return to IDLE.
- Beat count is `ceil(N / PPB)`. For example, 1x1 with PPB=2 gives one beat, `tdata[31:16]=0`, `tlast=1`.
- Backpressure:
  - A read is issued only if its data can be stored. A one-entry hold register absorbs the single in-flight return when the output stalls.
  - No texel is ever dropped or duplicated.
- `start` while `busy` is ignored: no `sizeError`, no effect.
- Counters are `TEX_ADDR_WIDTH+1` bits, so N = 2^TEX_ADDR_WIDTH does not wrap.

## Timing
- Reset values: `busy=0`, `done=0`, `sizeError=0`, `texelReadEn=0`, `texelReadAddr=0`, `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`.
- Reset mid-upload aborts immediately:
  - Next cycle, all outputs are at their reset values.
  - No `done`; any partial beat is discarded.
- With `start` sampled in cycle 0 and `tready` held high:
  - reads occur in cycles 1..N;
  - the first `tvalid` appears in cycle PPB+2;
  - one beat is emitted every PPB cycles;
  - `done` is high the cycle after the last handshake.
- `sizeError` pulses the cycle after the rejected `start`.
- AXIS rules:
  - Once `tvalid` rises, `tvalid`, `tdata` and `tlast` hold stable until `tready`.
  - `tvalid` never depends combinationally on `tready`.
- Throughput is 1 texel/cycle when not stalled. After `tready` deasserts, at most one further read is issued.

## Configuration
- `TEXTURE_UPLOADER_BYTE_SWAP_EN`:
  - Defined: each texel's bytes are reversed before packing, e.g. `0x1234` becomes `0x3412`. This requires `PIXEL_WIDTH` to be a multiple of 8.
  - Undefined: texels are packed unmodified.
- Timing is identical in both cases.

## Test plan
- 2x2, PPB=2, memory = `0x0001..0x0004`, `tready=1`:
  - 2 beats, `0x00020001`, `0x00040003` with `tlast`;
  - `done` pulses once; `busy` falls the same cycle.
- 1x1, memory[0]=`0xABCD`:
  - single beat `0x0000ABCD` with `tlast=1`, first `tvalid` in cycle 4.
- 8x8 with `tready` toggling pseudo-randomly:
  - 32 beats carry addresses 0..63 in order, with no loss or duplication;
  - `tdata` is stable during every stall;
  - `tlast` appears only on beat 31.
- `start` pulsed mid-upload: ignored. `w=9`, `h=8` in IDLE: `sizeError` pulse, `busy` stays 0.
- `reset` asserted during beat 3 of a 4x4 upload:
  - all outputs are 0 the next cycle, no `done`;
  - a fresh `start` then produces the full, correct stream.
- With `TEXTURE_UPLOADER_BYTE_SWAP_EN` defined: memory[0..1] = `0x1234`, `0x5678` gives beat `0x78563412`.
